// File: rtl/serial_align_ctrl_pkg.sv
// Shared definitions for the serial byte-alignment path: FSM state
// encodings, the default comma character and the occurrence-counter width.
package serial_align_ctrl_pkg;

  // Encoding 3 is never entered deliberately; the FSM maps it back to HUNT.
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2,
    ST_BAD  = 2'd3
  } state_e;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam int         CNT_W   = 4;

  // Saturating increment for the comma / misaligned-comma counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/s2p_shift_window.sv
// Serial shift register plus the combinational byte window that ends with
// the bit currently on the input. Shared with the serializer checker.
module s2p_shift_window
  import serial_align_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_window
);

  // Only the newest WIDTH-1 bits are ever needed to form the window, so the
  // oldest bit of the byte is not kept.
  logic [WIDTH-2:0] r_sr;

  // Shift one bit in per clock, MSB first.
  always_ff @(posedge i_clk) begin
    // NOTE: state is always written with <= so every flop samples the
    // pre-edge values regardless of statement order.
    if (i_rst) r_sr <= '0;
    else       r_sr <= {r_sr[WIDTH-3:0], i_bit};
  end

  assign o_window = {r_sr, i_bit};

endmodule

// File: rtl/serial_align_ctrl.sv
// Byte-alignment controller: hunts for the comma in the serial stream,
// acquires lock after LOCK_COUNT aligned commas, delivers aligned bytes while
// locked and drops lock after LOSS_COUNT misaligned commas.
module serial_align_ctrl
  import serial_align_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = K_COMMA,
  parameter int               LOCK_COUNT = 2,
  parameter int               LOSS_COUNT = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             VALID_OUT,
  output logic             COMMA_OUT,
  output logic             LOCKED,
  output logic [1:0]       STATE_OUT
);

  localparam int               BIT_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LOCK_CNT_V    = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] LOSS_CNT_V    = CNT_W'(LOSS_COUNT);
  localparam bit               LOCK_ON_FIRST = (LOCK_COUNT == 1);

  state_e           r_state;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_comma_cnt;
  logic [CNT_W-1:0] r_mis_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_comma;

  logic [WIDTH-1:0] w_window;
  logic             w_is_comma;
  logic             w_boundary;
  logic [BIT_W-1:0] w_bit_cnt_inc;
  logic [CNT_W-1:0] w_comma_inc;
  logic [CNT_W-1:0] w_mis_inc;

  state_e           w_state_nxt;
  logic [BIT_W-1:0] w_bit_cnt_nxt;
  logic [CNT_W-1:0] w_comma_cnt_nxt;
  logic [CNT_W-1:0] w_mis_cnt_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_valid_nxt;
  logic             w_comma_nxt;

  s2p_shift_window #(
    .WIDTH (WIDTH)
  ) u_window (
    .i_clk    (CLK),
    .i_rst    (RESET),
    .i_bit    (DATA_IN),
    .o_window (w_window)
  );

  assign w_is_comma    = (w_window == COMMA);
  assign w_boundary    = (r_bit_cnt == BIT_LAST);
  assign w_bit_cnt_inc = w_boundary ? '0 : r_bit_cnt + 1'b1;
  assign w_comma_inc   = sat_inc(r_comma_cnt);
  assign w_mis_inc     = sat_inc(r_mis_cnt);

  // State register; reset wins over any transition in progress.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_HUNT;
    else       r_state <= w_state_nxt;
  end

  // Next-state, counter and output-strobe decisions for the current cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned and no latch is inferred.
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = w_bit_cnt_inc;
    w_comma_cnt_nxt = r_comma_cnt;
    w_mis_cnt_nxt   = r_mis_cnt;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_comma_nxt     = 1'b0;

    case (r_state)
      ST_HUNT: begin
        // Any comma is a candidate boundary: realign the bit counter to it.
        if (w_is_comma) begin
          w_bit_cnt_nxt   = '0;
          w_comma_cnt_nxt = CNT_W'(1);
          if (LOCK_ON_FIRST) begin
            w_state_nxt   = ST_LOCK;
            w_mis_cnt_nxt = '0;
          end else begin
            w_state_nxt   = ST_SYNC;
          end
        end
      end

      ST_SYNC: begin
        // Only commas on the candidate boundary count toward lock.
        if (w_boundary) begin
          if (w_is_comma) begin
            w_comma_cnt_nxt = w_comma_inc;
            if (w_comma_inc >= LOCK_CNT_V) begin
              w_state_nxt   = ST_LOCK;
              w_mis_cnt_nxt = '0;
            end
          end else begin
            w_state_nxt = ST_HUNT;
          end
        end
      end

      ST_LOCK: begin
        // A misaligned comma takes priority over delivery; the two cannot
        // actually coincide because a cycle is a boundary or it is not.
        if (w_is_comma && !w_boundary) begin
          w_mis_cnt_nxt = w_mis_inc;
          if (w_mis_inc == LOSS_CNT_V) w_state_nxt = ST_HUNT;
        end else if (w_boundary) begin
          w_data_nxt  = w_window;
          w_valid_nxt = 1'b1;
          w_comma_nxt = w_is_comma;
          if (w_is_comma) w_mis_cnt_nxt = '0;
        end
      end

      default: w_state_nxt = ST_HUNT;
    endcase
  end

  // Counters and output registers; data is held across a drop to HUNT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bit_cnt   <= '0;
      r_comma_cnt <= '0;
      r_mis_cnt   <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_comma     <= 1'b0;
    end else begin
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_mis_cnt   <= w_mis_cnt_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_comma     <= w_comma_nxt;
    end
  end

  assign DATA_OUT  = r_data;
  assign VALID_OUT = r_valid;
  assign COMMA_OUT = r_comma;
  assign LOCKED    = (r_state == ST_LOCK);
  assign STATE_OUT = r_state;

endmodule

// File: tb/tb_serial_align_ctrl.sv
// Bench for serial_align_ctrl: two instances (LOCK_COUNT 1 and 2, LOSS_COUNT
// 3) share one serial stream; every cycle both are compared to a behavioural
// model that tracks mode, byte phase and comma counts from the stream itself.
module tb_serial_align_ctrl;

  localparam int K_BC = 8'hBC;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;

  logic [7:0] a_data,  b_data;
  logic       a_valid, b_valid;
  logic       a_comma, b_comma;
  logic       a_locked, b_locked;
  logic [1:0] a_state, b_state;

  always #5 clk = ~clk;

  serial_align_ctrl #(
    .WIDTH (8), .COMMA (8'hBC), .LOCK_COUNT (1), .LOSS_COUNT (3)
  ) dut_a (
    .CLK (clk), .RESET (rst), .DATA_IN (din),
    .DATA_OUT (a_data), .VALID_OUT (a_valid), .COMMA_OUT (a_comma),
    .LOCKED (a_locked), .STATE_OUT (a_state)
  );

  serial_align_ctrl #(
    .WIDTH (8), .COMMA (8'hBC), .LOCK_COUNT (2), .LOSS_COUNT (3)
  ) dut_b (
    .CLK (clk), .RESET (rst), .DATA_IN (din),
    .DATA_OUT (b_data), .VALID_OUT (b_valid), .COMMA_OUT (b_comma),
    .LOCKED (b_locked), .STATE_OUT (b_state)
  );

  // mode: 0 hunting, 1 confirming, 2 locked. phase: bits since the
  // believed byte start, 7 meaning the current bit closes a byte.
  typedef struct {
    int lock_need;
    int loss_need;
    int mode;
    int phase;
    int good;
    int bad;
    int data;
    bit valid;
    bit comma;
  } model_t;

  model_t mdl_a, mdl_b;
  int     hist;
  int     cycle   = 0;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_fail   = 0;

  function automatic model_t model_clear(input int lock_need, input int loss_need);
    model_t m;
    m.lock_need = lock_need;
    m.loss_need = loss_need;
    m.mode  = 0;
    m.phase = 0;
    m.good  = 0;
    m.bad   = 0;
    m.data  = 0;
    m.valid = 1'b0;
    m.comma = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m_in, input int win);
    model_t m = m_in;
    bit at_end = (m.phase == 7);
    m.phase = (m.phase + 1) % 8;
    m.valid = 1'b0;
    m.comma = 1'b0;
    if (m.mode == 0) begin
      if (win == K_BC) begin
        m.phase = 0;
        m.good  = 1;
        if (m.lock_need == 1) begin m.mode = 2; m.bad = 0; end
        else                  m.mode = 1;
      end
    end else if (m.mode == 1) begin
      if (at_end) begin
        if (win == K_BC) begin
          m.good = (m.good < 15) ? m.good + 1 : 15;
          if (m.good >= m.lock_need) begin m.mode = 2; m.bad = 0; end
        end else begin
          m.mode = 0;
        end
      end
    end else begin
      if (at_end) begin
        m.data  = win;
        m.valid = 1'b1;
        m.comma = (win == K_BC);
        if (m.comma) m.bad = 0;
      end else if (win == K_BC) begin
        if (m.bad + 1 == m.loss_need) m.mode = 0;
        m.bad = (m.bad < 15) ? m.bad + 1 : 15;
      end
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input model_t m, input logic [7:0] d,
                           input logic v, input logic c, input logic l,
                           input logic [1:0] s);
    check($sformatf("%s.data@%0d",   nm, cycle), 32'(d), 32'(m.data));
    check($sformatf("%s.valid@%0d",  nm, cycle), 32'(v), 32'(m.valid));
    check($sformatf("%s.comma@%0d",  nm, cycle), 32'(c), 32'(m.comma));
    check($sformatf("%s.locked@%0d", nm, cycle), 32'(l), 32'(m.mode == 2));
    check($sformatf("%s.state@%0d",  nm, cycle), 32'(s), 32'(m.mode));
  endtask

  // Drive one bit (optionally with RESET), advance the model, check at negedge.
  task automatic send_bit(input logic b, input logic r);
    int win;
    din = b;
    rst = r;
    @(posedge clk);
    if (r) begin
      mdl_a = model_clear(1, 3);
      mdl_b = model_clear(2, 3);
      hist  = 0;
    end else begin
      win   = ((hist << 1) | int'(b)) & 255;
      mdl_a = model_step(mdl_a, win);
      mdl_b = model_step(mdl_b, win);
      hist  = win;
    end
    @(negedge clk);
    cycle++;
    check_dut("a", mdl_a, a_data, a_valid, a_comma, a_locked, a_state);
    check_dut("b", mdl_b, b_data, b_valid, b_comma, b_locked, b_state);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    int         r;

    // 1. Reset held two edges while data toggles.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check("rst.a_locked", 32'(a_locked), 32'd0);
    check("rst.b_state",  32'(b_state),  32'd0);
    check("rst.b_data",   32'(b_data),   32'd0);

    // 2. LOCK_COUNT=1: junk, comma, then three data bytes.
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    send_byte(8'hBC);
    check("lk1.locked_after_bc", 32'(a_locked), 32'd1);
    send_byte(8'hAA);
    check("lk1.aa_valid", 32'(a_valid), 32'd1);
    check("lk1.aa_data",  32'(a_data),  32'hAA);
    check("lk1.aa_comma", 32'(a_comma), 32'd0);
    send_byte(8'h0C);
    check("lk1.0c_data",  32'(a_data),  32'h0C);
    send_byte(8'h55);
    check("lk1.55_data",  32'(a_data),  32'h55);
    check("lk1.55_valid", 32'(a_valid), 32'd1);

    // 3. LOCK_COUNT=2: a broken pair, then a good pair and a data byte.
    send_byte(8'hBC);
    send_byte(8'h11);
    check("lk2.hunt_at_11", 32'(b_state),  32'd0);
    check("lk2.unlocked",   32'(b_locked), 32'd0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h3C);
    check("lk2.locked",  32'(b_locked), 32'd1);
    check("lk2.3c_data", 32'(b_data),   32'h3C);

    // 4. Aligned comma while locked is delivered and flagged.
    send_byte(8'hBC);
    check("al.b_comma", 32'(b_comma), 32'd1);
    check("al.b_data",  32'(b_data),  32'hBC);

    // 5. Three commas slipped by three bits (inside 17,80) cause loss of lock.
    send_byte(8'h17); send_byte(8'h80); send_byte(8'hA5);
    send_byte(8'h17); send_byte(8'h80); send_byte(8'hA5);
    send_byte(8'h17); send_byte(8'h80);
    check("loss.b_locked", 32'(b_locked), 32'd0);
    check("loss.b_state",  32'(b_state),  32'd0);
    check("loss.b_hold",   32'(b_data),   32'h17);

    // 6. Relock, then reset on the boundary edge of a byte.
    send_byte(8'hBC);
    send_byte(8'hBC);
    rb = 8'($urandom_range(255, 0));
    for (int i = 7; i >= 1; i--) send_bit(rb[i], 1'b0);
    send_bit(rb[0], 1'b1);
    check("mrst.b_valid", 32'(b_valid), 32'd0);
    check("mrst.b_data",  32'(b_data),  32'd0);
    check("mrst.a_state", 32'(a_state), 32'd0);

    // 7. Random traffic: data, aligned commas, bit slips, slipped commas.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(9, 0);
      if (r <= 1) begin
        send_byte(8'hBC);
      end else if (r == 2) begin
        for (int k = 0; k < $urandom_range(3, 1); k++)
          send_bit(1'($urandom_range(1, 0)), 1'b0);
      end else if (r == 3) begin
        send_byte(8'h17);
        send_byte(8'h80);
      end else begin
        send_byte(8'($urandom_range(255, 0)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_align_ctrl.md
# serial_align_ctrl

Byte-alignment controller for the serial-to-parallel path: it watches the 1-bit serial stream (MSB first, one bit per CLK), hunts for the comma byte, and establishes byte lock after a programmable number of aligned commas. While locked, it delivers aligned parallel bytes with a one-cycle valid strobe and drops lock after repeated misaligned commas. It sits between the serial input pin and the downstream byte consumers, and decides where byte boundaries fall.

## Interface
Parameters:
- `WIDTH`, 8: byte width in bits.
- `COMMA`, 8'hBC: alignment character.
- `LOCK_COUNT`, 2: number of consecutive aligned commas needed for lock. Range 1–15.
- `LOSS_COUNT`, 3: number of misaligned commas, without an intervening aligned comma, that cause loss of lock. Range 1–15.

Ports:
- `CLK` input 1: single clock; all logic on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `DATA_IN` input 1: serial data bit, sampled every rising edge, MSB first.
- `DATA_OUT` output WIDTH: last aligned byte; holds its value between strobes.
- `VALID_OUT` output 1: one-cycle pulse when `DATA_OUT` is updated.
- `COMMA_OUT` output 1: qualifies `VALID_OUT`; high when the delivered byte equals `COMMA`.
- `LOCKED` output 1: high while the FSM is in LOCK.
- `STATE_OUT` output 2: current FSM state, for debug.

## Operation
- Shift register `sr[WIDTH-1:0]` is updated every cycle as `sr <= {sr[WIDTH-2:0], DATA_IN}`.
- Combinational window `w = {sr[WIDTH-2:0], DATA_IN}` is the byte that ends with the current bit.
- Bit counter `bit_cnt` runs 0..WIDTH-1 and wraps. A boundary occurs when `bit_cnt == WIDTH-1`.
- State encoding: HUNT=0, SYNC=1, LOCK=2. Value 3 is illegal and recovers to HUNT.
- HUNT:
  - Every cycle, if `w == COMMA`: set `bit_cnt <= 0`, `comma_cnt <= 1`.
  - Then go to LOCK if `LOCK_COUNT == 1`, otherwise go to SYNC.
- SYNC, at each boundary:
  - If `w == COMMA`, increment `comma_cnt`. When it reaches `LOCK_COUNT`, go to LOCK and clear `mis_cnt`.
  - If `w != COMMA`, go to HUNT. The same-cycle hunt check applies, so a comma in `w` at this point is treated as a new candidate.
  - Outside boundaries, stay in SYNC and advance `bit_cnt`.
- LOCK:
  - At each boundary: `DATA_OUT <= w`, `VALID_OUT <= 1`, `COMMA_OUT <= (w == COMMA)`.
  - An aligned comma clears `mis_cnt`.
  - A non-boundary cycle with `w == COMMA` increments `mis_cnt`. When `mis_cnt + 1 == LOSS_COUNT`, go to HUNT.
  - If both events occur in one cycle, misaligned-comma handling wins. This cannot happen at a true boundary, because a cycle is either a boundary or it is not.
- Commas consumed while acquiring lock (HUNT/SYNC) are never delivered. The first delivered byte is the one completing at the first boundary after entering LOCK.
- `comma_cnt` and `mis_cnt` are 4 bits wide and saturate at 15.

## Timing
- Reset: `DATA_OUT=0`, `VALID_OUT=0`, `COMMA_OUT=0`, `LOCKED=0`, `STATE_OUT=0` (HUNT), `sr=0`, `bit_cnt=0`, `comma_cnt=0`, `mis_cnt=0`.
- `RESET` asserted mid-operation takes effect on the next edge, overriding any transition or strobe in progress.
- Latency: if the last bit of a byte is sampled at edge k, then `DATA_OUT`/`VALID_OUT` are visible after edge k. The strobe lasts exactly one cycle.
- Strobe spacing in LOCK: exactly WIDTH cycles.
- `LOCKED` rises on the edge that completes the `LOCK_COUNT`-th comma. It falls on the edge that records the `LOSS_COUNT`-th misaligned comma.
- Going to HUNT resets no data outputs; `DATA_OUT` keeps its last value.
- `bit_cnt` keeps counting in LOCK and is realigned only from HUNT.

## Structure
- Shared include `s2p_defs.vh` holds:
  - state encodings `ST_HUNT`, `ST_SYNC`, `ST_LOCK`;
  - the default comma `K_COMMA = 8'hBC`;
  - the counter width constant `CNT_W = 4`.
- One sub-module, `s2p_shift_window`: the shift register plus the `w` output, reusable by the serializer checker.
- FSM, counters and output registers live in `serial_align_ctrl`.
- Target size: about 200 lines.

## Test plan
All scenarios run with WIDTH=8 and COMMA=8'hBC.
1. Reset behaviour: hold `RESET` for 2 edges while `DATA_IN` toggles. Required: all outputs 0, `STATE_OUT=0`.
2. Lock with `LOCK_COUNT=1`: send 4 junk bits, then BC, AA, 0C, 55. Required:
   - `LOCKED` rises on the edge after the last bit of BC;
   - strobes deliver AA, 0C, 55, spaced 8 cycles apart;
   - `COMMA_OUT=0` for all three.
3. Lock with `LOCK_COUNT=2`: send BC, 11, BC. Required: FSM returns to HUNT at the 11 byte and `LOCKED` stays 0. Then send BC, BC, 3C. Required: `LOCKED` rises after the second BC, and 3C is delivered.
4. Aligned comma in LOCK: send BC in the data stream. Required: `VALID_OUT=1`, `COMMA_OUT=1`, `DATA_OUT=BC`, `mis_cnt` cleared.
5. Loss of lock with `LOSS_COUNT=3`: while locked, inject BC shifted by 3 bits three times with no aligned comma in between. Required: `LOCKED` falls on the third injection, `STATE_OUT=0`, `DATA_OUT` holds its last value.
6. Reset mid-operation: assert `RESET` in the same cycle as a boundary while in LOCK. Required: no `VALID_OUT` strobe, all outputs 0 on the next edge.
